// File: rtl/cdc_handshake_src.sv
// Source-domain end of a 2-phase (toggle) req/ack CDC handshake carrying WIDTH-bit words.
// Optional 1-entry pending buffer enabled by defining CDC_SRC_SKID_EN; SYNC_STAGES legal range 2..4.
module cdc_handshake_src #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             src_clk,
  input  logic             src_rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack_async,
  output logic             busy,
  output logic             done,
  output logic             proto_err
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic                   xfer_c;
  logic [WIDTH-1:0]       data_d;
  logic                   req_d;
  logic                   ready_d;
  logic                   done_d;
  logic                   err_d;
`ifdef CDC_SRC_SKID_EN
  logic [WIDTH-1:0]       pend_data_q, pend_data_d;
  logic                   pend_vld_q, pend_vld_d;
`endif

  assign ack_s  = ack_sync_q[SYNC_STAGES-1];
  assign xfer_c = s_valid & s_ready;

  // Ack synchronizer; xfer_data is never sampled through it.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) ack_sync_q <= '0;
    else            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], xfer_ack_async};
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = xfer_data;
    req_d   = xfer_req;
    done_d  = 1'b0;
    err_d   = proto_err;
`ifdef CDC_SRC_SKID_EN
    pend_data_d = pend_data_q;
    pend_vld_d  = pend_vld_q;
`endif
    case (state_q)
      IDLE: begin
        if (ack_s != xfer_req) err_d = 1'b1;
        if (xfer_c) begin
          data_d  = s_data;
          req_d   = ~xfer_req;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == xfer_req) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef CDC_SRC_SKID_EN
        // Pending word launches on the completion edge; a new word may refill the buffer.
        if (ack_s == xfer_req && pend_vld_q) begin
          data_d     = pend_data_q;
          req_d      = ~xfer_req;
          state_d    = WAIT_ACK;
          pend_vld_d = 1'b0;
          if (xfer_c) begin
            pend_data_d = s_data;
            pend_vld_d  = 1'b1;
          end
        end else if (ack_s == xfer_req && xfer_c) begin
          data_d  = s_data;
          req_d   = ~xfer_req;
          state_d = WAIT_ACK;
        end else if (xfer_c) begin
          pend_data_d = s_data;
          pend_vld_d  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef CDC_SRC_SKID_EN
    ready_d = ~pend_vld_d;
`else
    // Ready only after a full idle cycle, so it returns the cycle after done.
    ready_d = (state_q == IDLE) && (state_d == IDLE);
`endif
  end

  // State and output registers.
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      state_q   <= IDLE;
      xfer_data <= RST_VAL;
      xfer_req  <= 1'b0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      xfer_data <= data_d;
      xfer_req  <= req_d;
      s_ready   <= ready_d;
      busy      <= (state_d == WAIT_ACK);
      done      <= done_d;
      proto_err <= err_d;
    end
  end

`ifdef CDC_SRC_SKID_EN
  always_ff @(posedge src_clk or negedge src_rst_n) begin
    if (!src_rst_n) begin
      pend_data_q <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      pend_data_q <= pend_data_d;
      pend_vld_q  <= pend_vld_d;
    end
  end
`endif

endmodule
